// File: rtl/eth_game_pkg.sv
// Shared definitions for game-message frames on the RMII link:
// ethertype, byte offsets, field widths and the receive FSM states.
package eth_game_pkg;

   localparam logic [15:0] ETHERTYPE_DEF = 16'h88B5;

   localparam int CNT_W = 5;

   localparam logic [CNT_W-1:0] OFF_TYPE_HI = 5'd12;
   localparam logic [CNT_W-1:0] OFF_TYPE_LO = 5'd13;
   localparam logic [CNT_W-1:0] OFF_X_HI    = 5'd14;
   localparam logic [CNT_W-1:0] OFF_X_LO    = 5'd15;
   localparam logic [CNT_W-1:0] OFF_Y_HI    = 5'd16;
   localparam logic [CNT_W-1:0] OFF_Y_LO    = 5'd17;
   localparam logic [CNT_W-1:0] OFF_DIR_HI  = 5'd18;
   localparam logic [CNT_W-1:0] OFF_DIR_LO  = 5'd19;
   localparam logic [CNT_W-1:0] OFF_STAT    = 5'd20;
   localparam logic [CNT_W-1:0] OFF_CSUM    = 5'd21;

   localparam int PAYLOAD_LEN = 8;

   localparam int X_W    = 11;
   localparam int Y_W    = 11;
   localparam int DIR_W  = 9;
   localparam int STAT_W = 2;

   localparam logic [15:0] DIR_LIMIT = 16'd360;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      DRAIN,
      DISCARD
   } rx_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/dibit_to_byte.sv
// Packs RMII dibits (LSB dibit first) into bytes.
// Ports: eth_clk, eth_rst, axiov, axiod in; rx_byte[7:0], byte_valid out.
module dibit_to_byte (
   input  logic       eth_clk,
   input  logic       eth_rst,
   input  logic       axiov,
   input  logic [1:0] axiod,
   output logic [7:0] rx_byte,
   output logic       byte_valid
);

   logic [1:0] phase;
   logic [5:0] acc;

   always_ff @(posedge eth_clk or posedge eth_rst) begin
      if (eth_rst) begin
         phase <= 2'd0;
         acc   <= 6'd0;
      end else if (!axiov) begin
         phase <= 2'd0;
      end else begin
         phase <= phase + 2'd1;
         acc   <= {axiod, acc[5:2]};
      end
   end

   // Fourth dibit completes the byte in the same cycle it arrives.
   assign byte_valid = axiov && (phase == 2'd3);
   assign rx_byte    = {axiod, acc};

endmodule

// File: rtl/opponent_decode.sv
// Decodes opponent position/heading/status game frames from RMII.
// Ports: eth_clk, eth_rst, axiov, axiod in; opponent_* fields,
// msg_valid pulse, stale flag and drop_count out.
module opponent_decode
   import eth_game_pkg::*;
#(
   parameter logic [15:0] ETHERTYPE      = ETHERTYPE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
   input  logic              eth_clk,
   input  logic              eth_rst,
   input  logic              axiov,
   input  logic [1:0]        axiod,
   output logic [X_W-1:0]    opponent_x,
   output logic [Y_W-1:0]    opponent_y,
   output logic [DIR_W-1:0]  opponent_dir,
   output logic [STAT_W-1:0] opponent_stat,
   output logic              msg_valid,
   output logic              stale,
   output logic [7:0]        drop_count
);

   localparam int TW = (TIMEOUT_CYCLES < 1) ? 1
                     : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

   logic [7:0]       rx_byte;
   logic             rx_valid;
   rx_state_t        state;
   logic [CNT_W-1:0] byte_cnt;
   logic [7:0]       type_hi;
   logic [7:0]       csum;
   logic [15:0]      x_r;
   logic [15:0]      y_r;
   logic [15:0]      dir_r;
   logic [7:0]       stat_r;
   logic             frame_ok;
   logic             chk_ok;
   logic             accept;
   logic [TW-1:0]    timer;

   dibit_to_byte u_d2b (
      .eth_clk    (eth_clk),
      .eth_rst    (eth_rst),
      .axiov      (axiov),
      .axiod      (axiod),
      .rx_byte    (rx_byte),
      .byte_valid (rx_valid)
   );

   // Evaluated while the checksum byte is on rx_byte.
   always_comb begin
      chk_ok = (csum == rx_byte)
            && (x_r[15:11] == 5'd0)
            && (y_r[15:11] == 5'd0)
            && (dir_r < DIR_LIMIT)
            && (stat_r[7:2] == 6'd0);
   end

   assign accept = (state == DRAIN) && !axiov && frame_ok;
   assign stale  = (timer == T_MAX);

   always_ff @(posedge eth_clk or posedge eth_rst) begin
      if (eth_rst) begin
         state         <= DISCARD;
         byte_cnt      <= '0;
         type_hi       <= 8'd0;
         csum          <= 8'd0;
         x_r           <= 16'd0;
         y_r           <= 16'd0;
         dir_r         <= 16'd0;
         stat_r        <= 8'd0;
         frame_ok      <= 1'b0;
         opponent_x    <= '0;
         opponent_y    <= '0;
         opponent_dir  <= '0;
         opponent_stat <= '0;
         msg_valid     <= 1'b0;
         drop_count    <= 8'd0;
      end else begin
         msg_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (axiov) begin
                  state    <= HEADER;
                  byte_cnt <= '0;
                  csum     <= 8'd0;
               end
            end
            HEADER: begin
               if (!axiov) begin
                  state      <= IDLE;
                  drop_count <= sat_inc8(drop_count);
               end else if (rx_valid) begin
                  byte_cnt <= byte_cnt + 5'd1;
                  if (byte_cnt == OFF_TYPE_HI)
                     type_hi <= rx_byte;
                  if (byte_cnt == OFF_TYPE_LO) begin
                     if ({type_hi, rx_byte} == ETHERTYPE) begin
                        state <= PAYLOAD;
                     end else begin
                        state      <= DISCARD;
                        drop_count <= sat_inc8(drop_count);
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (!axiov) begin
                  state      <= IDLE;
                  drop_count <= sat_inc8(drop_count);
               end else if (rx_valid) begin
                  byte_cnt <= byte_cnt + 5'd1;
                  if (byte_cnt != OFF_CSUM)
                     csum <= csum ^ rx_byte;
                  unique case (byte_cnt)
                     OFF_X_HI:   x_r[15:8]   <= rx_byte;
                     OFF_X_LO:   x_r[7:0]    <= rx_byte;
                     OFF_Y_HI:   y_r[15:8]   <= rx_byte;
                     OFF_Y_LO:   y_r[7:0]    <= rx_byte;
                     OFF_DIR_HI: dir_r[15:8] <= rx_byte;
                     OFF_DIR_LO: dir_r[7:0]  <= rx_byte;
                     OFF_STAT:   stat_r      <= rx_byte;
                     OFF_CSUM: begin
                        frame_ok <= chk_ok;
                        state    <= DRAIN;
                     end
                     default: ;
                  endcase
               end
            end
            DRAIN: begin
               if (!axiov) begin
                  state <= IDLE;
                  if (frame_ok) begin
                     opponent_x    <= x_r[X_W-1:0];
                     opponent_y    <= y_r[Y_W-1:0];
                     opponent_dir  <= dir_r[DIR_W-1:0];
                     opponent_stat <= stat_r[STAT_W-1:0];
                     msg_valid     <= 1'b1;
                  end else begin
                     drop_count <= sat_inc8(drop_count);
                  end
               end
            end
            DISCARD: begin
               if (!axiov)
                  state <= IDLE;
            end
            default: state <= DISCARD;
         endcase
      end
   end

   // Accept wins over saturation so stale drops on the accept edge.
   always_ff @(posedge eth_clk or posedge eth_rst) begin
      if (eth_rst)
         timer <= T_MAX;
      else if (accept)
         timer <= '0;
      else if (timer != T_MAX)
         timer <= timer + TW'(1);
   end

endmodule
